// File: rtl/if_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
//
// Contents:
//   IFQ_XLEN      default PC / instruction width
//   NOP           instruction decode substitutes while the queue shows no entry
//   ifq_entry_t   packed queue entry {pc, instr, misaligned}
//   is_misaligned flags a PC that is not 4-byte aligned
package if_pkg;

  localparam int IFQ_XLEN = 32;

  localparam logic [IFQ_XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [IFQ_XLEN-1:0] instr;
    logic                misaligned;
  } ifq_entry_t;

  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ifq_ptr.sv
// Wrap-around pointer register for the instruction queue.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, pointer -> 0
//   i_clr  synchronous clear (takes priority over i_inc)
//   i_inc  advance the pointer by one, wrapping modulo DEPTH
//   o_ptr  current pointer value
module ifq_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clr,
  input  logic                       i_inc,
  output logic [$clog2(DEPTH)-1:0]   o_ptr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      // DEPTH is a power of two, so natural overflow is the modulo wrap.
      r_ptr <= r_ptr + PW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: a valid/ready FIFO of
// {pc, instr, misaligned} entries with a synchronous flush for redirects.
//
// Optional feature (macro IFQ_BYPASS_EN): when the queue is empty and fetch
// presents an entry (no flush), that entry is shown on out_* in the same
// cycle; if decode takes it, it is never written and count stays 0.
//
// Parameters:
//   DEPTH  number of entries, power of two, >= 2
//   XLEN   PC / instruction width; entries use if_pkg::ifq_entry_t, so this
//          must match IFQ_XLEN
//
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   flush              redirect; empties the queue at the edge, overrides transfers
//   in_valid/in_ready  fetch-side handshake; in_ready = not full
//   in_pc, in_instr    fetched entry
//   out_valid/out_ready decode-side handshake
//   out_pc, out_instr, out_misaligned  head entry (0 when nothing to show)
//   count              current occupancy
module if_id_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = IFQ_XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic                       out_misaligned,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ifq_entry_t    r_mem [DEPTH];
  logic [CW-1:0] r_count;

  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  ifq_entry_t    w_wr_entry;
  ifq_entry_t    w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  assign w_wr_entry.pc         = in_pc;
  assign w_wr_entry.instr      = in_instr;
  assign w_wr_entry.misaligned = is_misaligned(in_pc[1:0]);

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_empty && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // Flush cancels both sides. A bypassed entry that decode takes directly is
  // not written, which keeps count at 0.
  assign w_pop  = !w_empty && out_ready && !flush;
  assign w_push = in_valid && !w_full && !flush && !(w_bypass && out_ready);

  ifq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .i_clr (flush),
    .i_inc (w_push),
    .o_ptr (w_wr_ptr)
  );

  ifq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .i_clr (flush),
    .i_inc (w_pop),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  // NOTE: the storage array has no reset; entries are only read once count
  // says they were written, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= w_wr_entry;
    end
  end

  // NOTE: assign a default first so every path drives w_head and no latch forms.
  always_comb begin
    w_head = '0;
    if (!w_empty) begin
      w_head = r_mem[w_rd_ptr];
    end else if (w_bypass) begin
      w_head = w_wr_entry;
    end
  end

  assign in_ready       = !w_full;
  assign out_valid      = !w_empty || w_bypass;
  assign out_pc         = w_head.pc;
  assign out_instr      = w_head.instr;
  assign out_misaligned = w_head.misaligned;
  assign count          = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a random phase,
// all compared against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_misaligned;
  logic [CW-1:0]   count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } mentry_t;

  mentry_t model_q[$];

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misaligned (out_misaligned),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bypass_now();
`ifdef IFQ_BYPASS_EN
    return model_q.size() == 0 && in_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  // Drive inputs mid-cycle, then let combinational outputs settle.
  task automatic drive(input logic iv, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  // Compare all outputs against what the model says should be visible now.
  task automatic compare(input string tag);
    int n;
    logic [XLEN-1:0] e_pc, e_instr;
    logic e_valid;
    n = model_q.size();
    e_valid = (n > 0) || bypass_now();
    e_pc = '0;
    e_instr = '0;
    if (n > 0) begin
      e_pc = model_q[0].pc;
      e_instr = model_q[0].instr;
    end else if (bypass_now()) begin
      e_pc = in_pc;
      e_instr = in_instr;
    end
    check({tag, ".count"}, 64'(count), 64'(n));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(n != DEPTH));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
    check({tag, ".out_pc"}, 64'(out_pc), 64'(e_pc));
    check({tag, ".out_instr"}, 64'(out_instr), 64'(e_instr));
    check({tag, ".out_mis"}, 64'(out_misaligned), 64'(e_pc[1:0] != 2'b00));
  endtask

  // Advance past the rising edge and apply the transfer rules to the model.
  task automatic tick();
    int n;
    bit byp, do_pop, do_push;
    n = model_q.size();
    byp = bypass_now();
    do_pop = (n > 0) && out_ready;
    do_push = in_valid && (n < DEPTH);
    @(posedge clk);
    if (flush) begin
      model_q.delete();
    end else if (byp && out_ready) begin
      // consumed straight from the input, never stored
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pc: in_pc, instr: in_instr});
    end
  endtask

  task automatic step(input string tag, input logic iv, input logic [XLEN-1:0] pc,
                      input logic [XLEN-1:0] ins, input logic ordy, input logic fl);
    drive(iv, pc, ins, ordy, fl);
    compare(tag);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_instr = '0;
    out_ready = 1'b0;
    #12;
    check("rst.count", 64'(count), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three enqueues with decode stalled.
    step("enq0", 1, 32'h0, 32'h0000_0013, 0, 0);
    step("enq1", 1, 32'h4, 32'h0050_0093, 0, 0);
    step("enq2", 1, 32'h8, 32'h00a0_0113, 0, 0);
    drive(0, '0, '0, 0, 0);
    compare("after3");
    check("after3.count", 64'(count), 64'd3);
    check("after3.head", 64'(out_pc), 64'h0);
    check("after3.in_ready", 64'(in_ready), 64'd1);
    tick();

    // Fill, attempt an overflow, then drain in order.
    step("enq3", 1, 32'hC, $urandom, 0, 0);
    drive(1, 32'h10, $urandom, 0, 0);
    compare("full");
    check("full.in_ready", 64'(in_ready), 64'd0);
    check("full.count", 64'(count), 64'd4);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, '0, '0, 1, 0);
      compare("drain");
      check("drain.order", 64'(out_pc), 64'(4 * i));
      tick();
    end
    step("drained", 0, '0, '0, 1, 0);

    // Steady stream at count 2 across pointer wrap.
    step("pre0", 1, 32'h200, $urandom, 0, 0);
    step("pre1", 1, 32'h204, $urandom, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h208 + 32'(4 * i), $urandom, 1, 0);
      compare("stream");
      check("stream.count", 64'(count), 64'd2);
      tick();
    end

    // Flush at count 3 with a concurrent enqueue.
    step("pre2", 1, 32'h300, $urandom, 0, 0);
    step("flush", 1, 32'h20, $urandom, 0, 1);
    drive(0, '0, '0, 0, 0);
    compare("postflush");
    check("postflush.count", 64'(count), 64'd0);
    check("postflush.out_valid", 64'(out_valid), 64'd0);
    tick();
    step("enq40", 1, 32'h40, 32'h1234_5678, 0, 0);
    drive(0, '0, '0, 0, 0);
    compare("head40");
    check("head40.pc", 64'(out_pc), 64'h40);
    tick();
    step("flush_hold0", 1, 32'h44, $urandom, 1, 1);
    step("flush_hold1", 1, 32'h48, $urandom, 1, 1);
    step("flush_hold2", 0, '0, '0, 0, 0);

    // Misalignment tag.
    step("mis6", 1, 32'h6, $urandom, 0, 0);
    step("mis8", 1, 32'h8, $urandom, 0, 0);
    drive(0, '0, '0, 1, 0);
    check("mis.pc6", 64'(out_misaligned), 64'd1);
    compare("mis_a");
    tick();
    drive(0, '0, '0, 1, 0);
    check("mis.pc8", 64'(out_misaligned), 64'd0);
    compare("mis_b");
    tick();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    // Ensure the queue holds entries, then pulse reset off the clock edges.
    step("prer0", 1, 32'h500, $urandom, 0, 0);
    step("prer1", 1, 32'h504, $urandom, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("arst.count", 64'(count), 64'd0);
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.in_ready", 64'(in_ready), 64'd1);
    #2 reset = 1'b0;
    model_q.delete();
    step("postrst", 0, '0, '0, 0, 0);

    // Empty queue, entry presented with decode ready.
    drive(1, 32'h100, 32'h0000_0013, 1, 0);
    compare("byp");
`ifdef IFQ_BYPASS_EN
    check("byp.out_valid", 64'(out_valid), 64'd1);
    check("byp.out_pc", 64'(out_pc), 64'h100);
    tick();
    drive(0, '0, '0, 1, 0);
    check("byp.count_after", 64'(count), 64'd0);
`else
    check("nobyp.out_valid", 64'(out_valid), 64'd0);
    tick();
    drive(0, '0, '0, 1, 0);
    check("nobyp.out_pc", 64'(out_pc), 64'h100);
`endif
    compare("byp_after");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
